// File: rtl/lifo_drain_ctrl.sv
// lifo_drain_ctrl
//   Unloads a burst of words from an attached LIFO and presents them, newest
//   first, on a valid/ready output stream.  The final word of each burst is
//   flagged with out_last, done pulses once the burst has completed, and
//   out_count reports how many words were actually sent.
//
//   Optional build macro: LIFO_DRAIN_AUTO_EN
//     defined   : a rising edge of lifo_full while idle starts a full-depth
//                 burst; an explicit start in the same cycle takes priority.
//     undefined : bursts start only on start; lifo_full is ignored.
//
// Ports
//   clk        in   rising-edge clock
//   reset      in   asynchronous, active-low reset
//   start      in   burst request, sampled only while idle
//   burst_len  in   words to pop; 0 or >LIFO_SIZE selects LIFO_SIZE
//   lifo_data  in   LIFO top-of-stack
//   lifo_val   in   LIFO non-empty
//   lifo_full  in   LIFO full
//   lifo_read  out  pop strobe to the LIFO (combinational)
//   out_data   out  output word
//   out_valid  out  out_data is valid
//   out_ready  in   sink accepts the word this cycle
//   out_last   out  marks the final word of the burst
//   busy       out  a burst is active; the LIFO writer must not write
//   done       out  one-cycle pulse at burst completion
//   out_count  out  words sent in the last burst, held until the next start
module lifo_drain_ctrl #(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned LIFO_SIZE = 8,
  localparam int unsigned CNT_W    = $clog2(LIFO_SIZE) + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [CNT_W-1:0]  burst_len,
  input  logic [DATA_W-1:0] lifo_data,
  input  logic              lifo_val,
  input  logic              lifo_full,
  output logic              lifo_read,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  out_count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] SIZE_C = CNT_W'(LIFO_SIZE);

  state_t            state;
  logic [CNT_W-1:0]  target;
  logic [CNT_W-1:0]  popped;
  logic              hold_v;
  logic [DATA_W-1:0] hold_d;
  logic              hold_move;
  logic              accept;
  logic              go;
  logic [CNT_W-1:0]  go_target;
  logic [CNT_W-1:0]  len_mapped;

  assign len_mapped = ((burst_len == '0) || (burst_len > SIZE_C)) ? SIZE_C : burst_len;

`ifdef LIFO_DRAIN_AUTO_EN
  logic full_q;
  logic auto_rise;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) full_q <= 1'b0;
    else        full_q <= lifo_full;
  end

  assign auto_rise = lifo_full & ~full_q;
  assign go        = start | auto_rise;
  assign go_target = start ? len_mapped : SIZE_C;
`else
  logic unused_full;
  assign unused_full = lifo_full;
  assign go          = start;
  assign go_target   = len_mapped;
`endif

  // The hold register may refill in the same cycle it hands its word on.
  assign hold_move = hold_v & (~out_valid | out_ready);
  assign lifo_read = (state == RUN) & lifo_val & (popped < target) & (~hold_v | hold_move);
  assign accept    = out_valid & out_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      target    <= '0;
      popped    <= '0;
      hold_v    <= 1'b0;
      hold_d    <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      out_count <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (go) begin
            target    <= go_target;
            popped    <= '0;
            out_count <= '0;
            busy      <= 1'b1;
            if (lifo_val) begin
              state <= RUN;
            end else begin
              state <= FIN;
              done  <= 1'b1;
            end
          end
        end

        RUN: begin
          if (lifo_read) begin
            hold_v <= 1'b1;
            hold_d <= lifo_data;
            popped <= popped + 1'b1;
          end else if (hold_move) begin
            hold_v <= 1'b0;
          end

          // popped already counts the held word; lifo_val shows what is left
          // behind it, so an empty LIFO here makes the held word the last one.
          if (hold_move) begin
            out_valid <= 1'b1;
            out_data  <= hold_d;
            out_last  <= (popped == target) | ~lifo_val;
          end else if (accept) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
          end

          if (accept) begin
            if (out_count != SIZE_C) out_count <= out_count + 1'b1;
            if (out_last) begin
              state <= FIN;
              done  <= 1'b1;
            end
          end
        end

        FIN: begin
          state <= IDLE;
          busy  <= 1'b0;
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lifo_drain_ctrl.sv
module tb_lifo_drain_ctrl;

  logic       clk;
  logic       reset;
  logic       start;
  logic [3:0] burst_len;
  logic [7:0] lifo_data;
  logic       lifo_val;
  logic       lifo_full;
  logic       lifo_read;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       out_last;
  logic       busy;
  logic       done;
  logic [3:0] out_count;

  lifo_drain_ctrl #(.DATA_W(8), .LIFO_SIZE(8)) dut (
    .clk(clk), .reset(reset), .start(start), .burst_len(burst_len),
    .lifo_data(lifo_data), .lifo_val(lifo_val), .lifo_full(lifo_full),
    .lifo_read(lifo_read), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_last(out_last), .busy(busy), .done(done),
    .out_count(out_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- attached LIFO ----------------
  logic [7:0] stk [8];
  int         sp = 0;
  logic       push;
  logic [7:0] push_d;

  always @(posedge clk) begin
    if (lifo_read && sp > 0) sp <= sp - 1;
    else if (push && sp < 8) begin
      stk[sp] <= push_d;
      sp      <= sp + 1;
    end
  end
  assign lifo_data = (sp > 0) ? stk[sp-1] : 8'h00;
  assign lifo_val  = (sp > 0);
  assign lifo_full = (sp == 8);

  // ---------------- checking ----------------
  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input int act, input int exp_v);
    total++;
    if (act != exp_v) begin
      bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) t=%0t", nm, act, act, exp_v, exp_v, $time);
    end
  endtask

  function automatic int map_len(input int l);
    return (l == 0 || l > 8) ? 8 : l;
  endfunction

  // Reference model: a burst sends min(target, depth) words, newest first.
  int         phase = 0;      // 0 idle, 1 sending, 2 completion cycle
  logic [7:0] exp_q[$];
  int         exp_cnt = 0;
  int         tgt = 0;
  int         pops = 0;
  int         accs = 0;
  logic [7:0] acc_log[$];
  int         acc_cyc[$];
  int         cyc = 0;
  int         start_cyc = 0;
  int         done_cyc = 0;
  logic       prev_v = 0, prev_r = 0, prev_l = 0, prev_full = 0;
  logic [7:0] prev_d = 0;

  always @(negedge clk) begin
    int nxt;
    int n;
    bit go;
    bit acc_now;
    cyc++;
    if (!reset) begin
      phase = 0; exp_q.delete(); exp_cnt = 0; pops = 0; accs = 0;
      prev_v = 0; prev_r = 0; prev_full = 0;
    end else begin
      acc_now = out_valid && out_ready;
      chk("busy", busy, phase != 0);
      chk("done", done, phase == 2);
      chk("out_count", out_count, exp_cnt);
      if (done) done_cyc = cyc;
      if (phase == 0) chk("idle_valid", out_valid, 0);
      if (prev_v && !prev_r) begin
        chk("stall_valid", out_valid, 1);
        chk("stall_data", out_data, prev_d);
        chk("stall_last", out_last, prev_l);
      end
      if (lifo_read) begin
        chk("read_nonempty", lifo_val, 1);
        chk("read_room", (pops - accs - int'(acc_now)) < 2, 1);
        chk("read_target", pops < tgt, 1);
        pops++;
      end
      nxt = phase;
      case (phase)
        0: begin
          go  = start;
          n   = map_len(burst_len);
`ifdef LIFO_DRAIN_AUTO_EN
          if (!start && lifo_full && !prev_full) begin
            go = 1;
            n  = 8;
          end
`endif
          if (go) begin
            tgt = n;
            if (n > sp) n = sp;
            exp_q.delete();
            for (int i = 0; i < n; i++) exp_q.push_back(stk[sp-1-i]);
            exp_cnt = 0; pops = 0; accs = 0;
            start_cyc = cyc;
            nxt = (n > 0) ? 1 : 2;
          end
        end
        1: begin
          if (acc_now) begin
            if (exp_q.size() == 0) begin
              chk("extra_word", 1, 0);
            end else begin
              chk("data", out_data, exp_q[0]);
              chk("last", out_last, exp_q.size() == 1);
              void'(exp_q.pop_front());
              acc_log.push_back(out_data);
              acc_cyc.push_back(cyc);
              accs++;
              if (exp_cnt < 8) exp_cnt++;
              if (exp_q.size() == 0) nxt = 2;
            end
          end
        end
        default: nxt = 0;
      endcase
      phase = nxt;
      prev_v = out_valid; prev_r = out_ready; prev_d = out_data; prev_l = out_last;
      prev_full = lifo_full;
    end
  end

  // ---------------- stimulus ----------------
  bit rnd_rdy = 0;
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1 out_ready = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  task automatic push_word(input logic [7:0] v);
    push = 1'b1; push_d = v;
    @(posedge clk);
    #1 push = 1'b0;
  endtask

  task automatic fill8();
    for (int i = 1; i <= 8; i++) push_word(8'(i));
  endtask

  task automatic do_start(input int len);
    start = 1'b1; burst_len = 4'(len);
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while (phase != 0 && k < 400) begin
      @(negedge clk);
      k++;
    end
    if (phase != 0) begin
      bad++; total++;
      $display("FAIL timeout: burst still active after %0d cycles", k);
    end
    @(negedge clk);
    @(posedge clk); #1;
  endtask

  initial begin
    int sp0;
    push = 0; push_d = 0; start = 0; burst_len = 0;
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", out_valid, 0); chk("rst_busy", busy, 0); chk("rst_done", done, 0);
    chk("rst_read", lifo_read, 0); chk("rst_data", out_data, 0); chk("rst_count", out_count, 0);
    chk("rst_last", out_last, 0);
    reset = 1'b1;
    @(posedge clk); #1;

    // Three words, burst_len 0 -> all three, back to back.
    acc_log.delete(); acc_cyc.delete();
    push_word(8'h11); push_word(8'h22); push_word(8'h33);
    do_start(0);
    wait_idle();
    chk("t1_n", acc_log.size(), 3);
    if (acc_log.size() == 3) begin
      chk("t1_w0", acc_log[0], 8'h33); chk("t1_w1", acc_log[1], 8'h22); chk("t1_w2", acc_log[2], 8'h11);
      chk("t1_b2b", acc_cyc[2] - acc_cyc[0], 2);
      chk("t1_done_lat", done_cyc - acc_cyc[2], 1);
    end
    chk("t1_count", out_count, 3);
    chk("t1_lifo_empty", lifo_val, 0);

    // Full LIFO, burst of 3.
    acc_log.delete();
    fill8();
    do_start(3);
    wait_idle();
    chk("t2_n", acc_log.size(), 3);
    if (acc_log.size() == 3) begin
      chk("t2_w0", acc_log[0], 8'h08); chk("t2_w2", acc_log[2], 8'h06);
    end
    chk("t2_count", out_count, 3);
    chk("t2_left", sp, 5);
    chk("t2_top", lifo_data, 8'h05);
    do_start(0);
    wait_idle();

    // Full LIFO, random back-pressure.
    acc_log.delete();
    fill8();
    rnd_rdy = 1;
    do_start(0);
    wait_idle();
    rnd_rdy = 0;
    chk("t3_n", acc_log.size(), 8);
    for (int i = 0; i < acc_log.size() && i < 8; i++) chk("t3_word", acc_log[i], 8 - i);

    // Empty LIFO.
    acc_log.delete();
    do_start(5);
    wait_idle();
    chk("t4_words", acc_log.size(), 0);
    chk("t4_done_lat", done_cyc - start_cyc, 1);
    chk("t4_count", out_count, 0);

    // Reset after two accepted words.
    acc_log.delete();
    fill8();
    do_start(0);
    for (int k = 0; k < 50 && acc_log.size() < 2; k++) @(negedge clk);
    chk("t5_two_acc", acc_log.size(), 2);
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    chk("t5_valid", out_valid, 0); chk("t5_busy", busy, 0); chk("t5_done", done, 0);
    chk("t5_read", lifo_read, 0); chk("t5_data", out_data, 0); chk("t5_count", out_count, 0);
    chk("t5_last", out_last, 0);
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1;
    sp0 = sp;
    acc_log.delete();
    do_start(0);
    wait_idle();
    chk("t5_after_n", acc_log.size(), sp0);
    chk("t5_after_count", out_count, sp0);

`ifdef LIFO_DRAIN_AUTO_EN
    // Filling the LIFO with no start launches a full burst.
    acc_log.delete();
    for (int i = 1; i <= 8; i++) push_word(8'(8'h40 + i));
    for (int k = 0; k < 5 && phase == 0; k++) @(negedge clk);
    chk("t6_auto_started", phase != 0, 1);
    wait_idle();
    chk("t6_n", acc_log.size(), 8);
    if (acc_log.size() == 8) chk("t6_oldest_last", acc_log[7], 8'h41);
    chk("t6_done_seen", done_cyc > start_cyc, 1);
`endif

    // Randomized bursts.
    for (int it = 0; it < 40; it++) begin
      int cap;
`ifdef LIFO_DRAIN_AUTO_EN
      cap = 7;
`else
      cap = 8;
`endif
      rnd_rdy = 0;
      if (sp < cap) begin
        int n;
        n = $urandom_range(0, cap - sp);
        for (int i = 0; i < n; i++) push_word(8'($urandom_range(0, 255)));
      end
      rnd_rdy = ($urandom_range(0, 1) == 1);
      do_start($urandom_range(0, 15));
      wait_idle();
    end
    rnd_rdy = 0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
